inst_prefetch_unit: RTL and testbench

- Parametrised instruction fetch front-end for the Cortex-M0 core; replaces the fixed single-cycle PC/MAR/IR fetch with a decoupled prefetch queue.
- Issues word-aligned reads to program ROM over a req/ack handshake and buffers returned halfwords.
- Delivers complete 16- or 32-bit Thumb instructions with their PC to decode through a valid/ready handshake.
- Handles branch redirects, including halfword-aligned targets.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/inst_prefetch_unit_if.sv | 30 +++
 rtl/halfword_fifo.sv | 58 +++++
 rtl/inst_prefetch_unit.sv | 152 +++++++++++++++
 tb/tb_inst_prefetch_unit.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction prefetch front-end.
// Latency: none (types and a combinational decode helper only).
// Backpressure: not applicable.
package fetch_pkg;

    localparam int HW_BYTES = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    // A Thumb halfword opens a 32-bit instruction when its top five bits are 11101, 11110 or 11111
    function automatic logic is_thumb32(input logic [15:0] hw);
        logic [4:0] op;
        logic       unused_low;
        op         = hw[15:11];
        unused_low = ^hw[10:0];
        return (op == 5'b11101) || (op == 5'b11110) || (op == 5'b11111);
    endfunction

endpackage

// File: rtl/inst_prefetch_unit_if.sv
// ROM read, decode delivery and branch redirect signals of the prefetch unit.
// Latency: none (wiring only).
// Backpressure: rom_req held until rom_ack; inst_valid held until inst_ready.
interface inst_prefetch_unit_if #(
    parameter int ADDR_W = 16
);
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_ack;
    logic [31:0]       rom_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_data;
    logic              inst_is32;
    logic [ADDR_W-1:0] inst_pc;
    logic              branch_valid;
    logic [ADDR_W-1:0] branch_target;

    // Prefetch unit side
    modport master (
        output rom_req, rom_addr, inst_valid, inst_data, inst_is32, inst_pc,
        input  rom_ack, rom_rdata, inst_ready, branch_valid, branch_target
    );

    // ROM, decode and branch unit side
    modport slave (
        input  rom_req, rom_addr, inst_valid, inst_data, inst_is32, inst_pc,
        output rom_ack, rom_rdata, inst_ready, branch_valid, branch_target
    );
endinterface

// File: rtl/halfword_fifo.sv
// Circular halfword queue taking up to two pushes and two pops per cycle.
// Latency: pushed entries are visible at the head one cycle later.
// Backpressure: none internally; the writer only pushes when two slots are free.
module halfword_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push0,
    input  logic [15:0]            push0_dat,
    input  logic                   push1,
    input  logic [15:0]            push1_dat,
    input  logic [1:0]             pop_n,
    output logic [15:0]            head0,
    output logic [15:0]            head1,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [1:0]    push_n;

    // push1 is only ever raised together with push0, so entries stay contiguous
    assign push_n = {1'b0, push0} + {1'b0, push1};
    assign head0  = mem[rd_ptr];
    assign head1  = mem[rd_ptr + PW'(1)];

    // Pointers wrap naturally because DEPTH is a power of two; flush wins over push/pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(pop_n);
            wr_ptr <= wr_ptr + PW'(push_n);
            count  <= count + CW'(push_n) - CW'(pop_n);
        end
    end

    // Storage write: first pushed halfword at wr_ptr, second just after it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (!flush) begin
            if (push0) mem[wr_ptr] <= push0_dat;
            if (push1) mem[wr_ptr + PW'(1)] <= push1_dat;
        end
    end
endmodule

// File: rtl/inst_prefetch_unit.sv
// Decoupled Thumb fetch: word reads from ROM, halfword queue, whole instructions to decode; PREFETCH_STATS_EN adds fetch/discard counters.
// Latency: ack to 16-bit inst_valid 1 cycle; branch to first rom_req 2 cycles.
// Backpressure: stops requesting below 2 free slots; inst_valid held until inst_ready.
module inst_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = 16,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic        clk,
    input  logic        rst,
`ifdef PREFETCH_STATS_EN
    output logic [31:0] stat_fetches,
    output logic [31:0] stat_discards,
`endif
    inst_prefetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] RESET_FETCH = {RESET_PC[ADDR_W-1:2], 2'b00};
    localparam logic [ADDR_W-1:0] RESET_HEAD  = {RESET_PC[ADDR_W-1:1], 1'b0};

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] head_pc;
    logic              skip_low;
    logic              start_req;
    logic              free_ok;
    logic              ack_take;
    logic              pop;
    logic [1:0]        pop_n;
    logic              head_is32;
    logic [15:0]       head0;
    logic [15:0]       head1;
    logic [CW-1:0]     count;
    logic              unused_tgt;

    assign unused_tgt = bus.branch_target[0];

    halfword_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.branch_valid),
        .push0     (ack_take),
        .push0_dat (skip_low ? bus.rom_rdata[31:16] : bus.rom_rdata[15:0]),
        .push1     (ack_take && !skip_low),
        .push1_dat (bus.rom_rdata[31:16]),
        .pop_n     (pop_n),
        .head0     (head0),
        .head1     (head1),
        .count     (count)
    );

    // A request only starts with room for a full word, so the queue cannot overflow
    assign free_ok   = (CW'(DEPTH) - count) >= CW'(2);
    // Data returned in the same cycle as a branch belongs to the old stream
    assign ack_take  = (state == REQ) && bus.rom_ack && !bus.branch_valid;
    assign head_is32 = is_thumb32(head0);

    assign bus.inst_valid = head_is32 ? (count >= CW'(2)) : (count != '0);
    assign bus.inst_is32  = head_is32;
    assign bus.inst_data  = head_is32 ? {head0, head1} : {16'h0000, head0};
    assign bus.inst_pc    = head_pc;
    assign bus.rom_addr   = req_addr;

    // A redirect takes precedence over the decode handshake
    assign pop   = bus.inst_valid && bus.inst_ready && !bus.branch_valid;
    assign pop_n = pop ? (head_is32 ? 2'd2 : 2'd1) : 2'd0;

    // Fetch state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and request strobe; an ack in DISCARD ends the stale read even if a new branch arrives
    always_comb begin
        state_nxt   = state;
        bus.rom_req = 1'b0;
        start_req   = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.branch_valid && free_ok) begin
                    state_nxt = REQ;
                    start_req = 1'b1;
                end
            end
            REQ: begin
                bus.rom_req = 1'b1;
                if (bus.rom_ack)           state_nxt = IDLE;
                else if (bus.branch_valid) state_nxt = DISCARD;
            end
            DISCARD: begin
                bus.rom_req = 1'b1;
                if (bus.rom_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request address is frozen for the life of a read, including while it is being discarded
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           req_addr <= RESET_FETCH;
        else if (start_req) req_addr <= fetch_pc;
    end

    // Fetch pointer and low-halfword skip for halfword-aligned targets
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_FETCH;
            skip_low <= RESET_PC[1];
        end else if (bus.branch_valid) begin
            fetch_pc <= {bus.branch_target[ADDR_W-1:2], 2'b00};
            skip_low <= bus.branch_target[1];
        end else if (ack_take) begin
            fetch_pc <= fetch_pc + ADDR_W'(2 * HW_BYTES);
            skip_low <= 1'b0;
        end
    end

    // PC of the instruction at the queue head
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  head_pc <= RESET_HEAD;
        else if (bus.branch_valid) head_pc <= {bus.branch_target[ADDR_W-1:1], 1'b0};
        else if (pop)              head_pc <= head_pc + (head_is32 ? ADDR_W'(2 * HW_BYTES) : ADDR_W'(HW_BYTES));
    end

`ifdef PREFETCH_STATS_EN
    logic [32:0] fetch_sum;
    logic [32:0] discard_sum;
    logic [2:0]  ack_drop;

    assign ack_drop    = (bus.rom_ack && ((state == DISCARD) || ((state == REQ) && bus.branch_valid))) ? 3'd2 : 3'd0;
    assign fetch_sum   = {1'b0, stat_fetches} + 33'(ack_take);
    assign discard_sum = {1'b0, stat_discards} + 33'(ack_drop) + (bus.branch_valid ? 33'(count) : 33'd0);

    // Saturating counters of accepted reads and halfwords thrown away
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_fetches  <= '0;
            stat_discards <= '0;
        end else begin
            stat_fetches  <= fetch_sum[32]   ? '1 : fetch_sum[31:0];
            stat_discards <= discard_sum[32] ? '1 : discard_sum[31:0];
        end
    end
`else
    // Statistics counters are not built in this configuration
`endif
endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Directed bench for inst_prefetch_unit: ROM model with programmable ack delay, request/instruction logs.
// Latency: checks sequence order plus the branch-to-request and split-word timing.
// Backpressure: exercises inst_ready held low until the queue fills.
module tb_inst_prefetch_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   ack_delay;
    int   acks_seen;
    logic [15:0] rom [256];
    logic [15:0] req_log [$];
    logic [15:0] pc_log [$];
    logic [31:0] dat_log [$];
    logic        is32_log [$];
`ifdef PREFETCH_STATS_EN
    logic [31:0] stat_fetches;
    logic [31:0] stat_discards;
`endif

    inst_prefetch_unit_if #(.ADDR_W(16)) bus ();

    inst_prefetch_unit #(.ADDR_W(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef PREFETCH_STATS_EN
        .stat_fetches  (stat_fetches),
        .stat_discards (stat_discards),
`endif
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ROM model: acks once rom_req has been seen for ack_delay cycles, data from the held address
    initial begin
        int         wait_cnt;
        logic [7:0] a;
        wait_cnt      = 0;
        bus.rom_ack   = 1'b0;
        bus.rom_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst || bus.rom_ack) begin
                bus.rom_ack = 1'b0;
                wait_cnt    = 0;
            end else if (bus.rom_req) begin
                if (wait_cnt >= ack_delay) begin
                    a             = bus.rom_addr[8:1];
                    bus.rom_ack   = 1'b1;
                    bus.rom_rdata = {rom[a + 8'd1], rom[a]};
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: logs each new request address, each ack, each accepted instruction
    initial begin
        logic req_q;
        req_q = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                req_q = 1'b0;
            end else begin
                if (bus.rom_req && !req_q) req_log.push_back(bus.rom_addr);
                if (bus.rom_req && bus.rom_ack) acks_seen++;
                if (bus.inst_valid && bus.inst_ready && !bus.branch_valid) begin
                    pc_log.push_back(bus.inst_pc);
                    dat_log.push_back(bus.inst_data);
                    is32_log.push_back(bus.inst_is32);
                end
                req_q = bus.rom_req;
            end
        end
    end

    task automatic clear_logs();
        req_log.delete();
        pc_log.delete();
        dat_log.delete();
        is32_log.delete();
        acks_seen = 0;
    endtask

    task automatic wait_insts(input int n);
        int cyc;
        cyc = 0;
        while (pc_log.size() < n && cyc < 300) begin
            @(posedge clk); #2;
            cyc++;
        end
    endtask

    // Stall decode until the queue is full and the front-end has stopped requesting
    task automatic quiesce();
        int idle_run;
        int cyc;
        idle_run = 0;
        cyc      = 0;
        bus.inst_ready = 1'b0;
        while (idle_run < 4 && cyc < 300) begin
            @(posedge clk); #2;
            if (bus.rom_req) idle_run = 0;
            else             idle_run++;
            cyc++;
        end
    endtask

    // One-cycle redirect; returns in the cycle after the branch edge with logs cleared
    task automatic do_branch(input logic [15:0] t);
        @(posedge clk); #1;
        bus.branch_valid  = 1'b1;
        bus.branch_target = t;
        @(posedge clk); #1;
        bus.branch_valid  = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (bus.rom_req !== 1'b0) begin errors++; $display("FAIL reset_rom_req: got %b want 0", bus.rom_req); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", bus.inst_valid); end
        checks++; if (bus.inst_pc !== 16'h0000) begin errors++; $display("FAIL reset_inst_pc: got %h want 0000", bus.inst_pc); end
        checks++; if (bus.rom_addr !== 16'h0000) begin errors++; $display("FAIL reset_rom_addr: got %h want 0000", bus.rom_addr); end
    endtask

    task automatic test_sequential();
        ack_delay      = 1;
        bus.inst_ready = 1'b1;
        @(posedge clk); #3;
        clear_logs();
        rst = 1'b1;
        wait_insts(3);
        checks++; if (req_log.size() < 2 || pc_log.size() < 3) begin errors++; $display("FAIL seq_count: got %0d req %0d inst want 2 3", req_log.size(), pc_log.size()); end
        else begin
            checks++; if (req_log[0] !== 16'h0000) begin errors++; $display("FAIL seq_addr0: got %h want 0000", req_log[0]); end
            checks++; if (req_log[1] !== 16'h0004) begin errors++; $display("FAIL seq_addr1: got %h want 0004", req_log[1]); end
            for (int i = 0; i < 3; i++) begin
                checks++; if (pc_log[i] !== 16'(2 * i)) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", i, pc_log[i], 16'(2 * i)); end
                checks++; if (is32_log[i] !== 1'b0) begin errors++; $display("FAIL seq_is32_%0d: got %b want 0", i, is32_log[i]); end
                checks++; if (dat_log[i] !== 32'h2000 + 32'(i)) begin errors++; $display("FAIL seq_data%0d: got %h want %h", i, dat_log[i], 32'h2000 + 32'(i)); end
            end
        end
    endtask

    task automatic test_bl_pair();
        ack_delay = 1;
        quiesce();
        do_branch(16'h0010);
        bus.inst_ready = 1'b1;
        wait_insts(2);
        checks++; if (pc_log.size() < 2) begin errors++; $display("FAIL bl_count: got %0d want 2", pc_log.size()); end
        else begin
            checks++; if (pc_log[0] !== 16'h0010) begin errors++; $display("FAIL bl_pc: got %h want 0010", pc_log[0]); end
            checks++; if (is32_log[0] !== 1'b1) begin errors++; $display("FAIL bl_is32: got %b want 1", is32_log[0]); end
            checks++; if (dat_log[0] !== 32'hF000F800) begin errors++; $display("FAIL bl_data: got %h want F000F800", dat_log[0]); end
            checks++; if (pc_log[1] !== 16'h0014 || dat_log[1] !== 32'h0000200A) begin errors++; $display("FAIL bl_next: got %h/%h want 0014/0000200A", pc_log[1], dat_log[1]); end
        end
    endtask

    task automatic test_branch_unaligned();
        ack_delay = 1;
        quiesce();
        do_branch(16'h0022);
        bus.inst_ready = 1'b1;
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL br_valid_after: got %b want 0", bus.inst_valid); end
        checks++; if (bus.rom_req !== 1'b0) begin errors++; $display("FAIL br_req_c1: got %b want 0", bus.rom_req); end
        @(posedge clk); #1;
        checks++; if (bus.rom_req !== 1'b1 || bus.rom_addr !== 16'h0020) begin errors++; $display("FAIL br_req_c2: got %b/%h want 1/0020", bus.rom_req, bus.rom_addr); end
        wait_insts(2);
        checks++; if (pc_log.size() < 2 || req_log.size() < 1) begin errors++; $display("FAIL br_count: got %0d want 2", pc_log.size()); end
        else begin
            checks++; if (req_log[0] !== 16'h0020) begin errors++; $display("FAIL br_addr: got %h want 0020", req_log[0]); end
            checks++; if (pc_log[0] !== 16'h0022 || dat_log[0] !== 32'h00002011) begin errors++; $display("FAIL br_first: got %h/%h want 0022/00002011", pc_log[0], dat_log[0]); end
            checks++; if (pc_log[1] !== 16'h0024) begin errors++; $display("FAIL br_second_pc: got %h want 0024", pc_log[1]); end
        end
    endtask

    task automatic test_branch_discard();
        logic [15:0] old_addr;
        int          cyc;
        ack_delay = 3;
        quiesce();
        do_branch(16'h0060);
        bus.inst_ready = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.rom_req && cyc < 50);
        old_addr = bus.rom_addr;
        checks++; if (old_addr !== 16'h0060) begin errors++; $display("FAIL disc_old_addr: got %h want 0060", old_addr); end
        do_branch(16'h0040);
        checks++; if (bus.rom_req !== 1'b1 || bus.rom_addr !== 16'h0060) begin errors++; $display("FAIL disc_hold: got %b/%h want 1/0060", bus.rom_req, bus.rom_addr); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL disc_valid: got %b want 0", bus.inst_valid); end
        wait_insts(1);
        checks++; if (pc_log.size() < 1 || req_log.size() < 1) begin errors++; $display("FAIL disc_count: got %0d want 1", pc_log.size()); end
        else begin
            checks++; if (req_log[0] !== 16'h0040) begin errors++; $display("FAIL disc_next_addr: got %h want 0040", req_log[0]); end
            checks++; if (pc_log[0] !== 16'h0040 || dat_log[0] !== 32'h00002020) begin errors++; $display("FAIL disc_first: got %h/%h want 0040/00002020", pc_log[0], dat_log[0]); end
        end
    endtask

    task automatic test_fill_drain();
        ack_delay = 1;
        quiesce();
        do_branch(16'h0080);
        repeat (30) @(posedge clk);
        #2;
        checks++; if (bus.rom_req !== 1'b0) begin errors++; $display("FAIL fill_req: got %b want 0", bus.rom_req); end
        checks++; if (req_log.size() != 2) begin errors++; $display("FAIL fill_reqs: got %0d want 2", req_log.size()); end
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0080) begin errors++; $display("FAIL fill_head: got %b/%h want 1/0080", bus.inst_valid, bus.inst_pc); end
        checks++; if (pc_log.size() != 0) begin errors++; $display("FAIL fill_nopop: got %0d want 0", pc_log.size()); end
        bus.inst_ready = 1'b1;
        wait_insts(4);
        checks++; if (pc_log.size() < 4) begin errors++; $display("FAIL drain_count: got %0d want 4", pc_log.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (pc_log[i] !== 16'h0080 + 16'(2 * i) || dat_log[i] !== 32'h2040 + 32'(i)) begin
                    errors++; $display("FAIL drain%0d: got %h/%h want %h/%h", i, pc_log[i], dat_log[i], 16'h0080 + 16'(2 * i), 32'h2040 + 32'(i));
                end
            end
        end
    endtask

    task automatic test_split32();
        int cyc;
        ack_delay = 5;
        quiesce();
        do_branch(16'h001E);
        bus.inst_ready = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.inst_valid && cyc < 100);
        checks++; if (acks_seen != 2) begin errors++; $display("FAIL split_acks_at_valid: got %0d want 2", acks_seen); end
        checks++; if (bus.inst_pc !== 16'h001E || bus.inst_is32 !== 1'b1) begin errors++; $display("FAIL split_head: got %h/%b want 001E/1", bus.inst_pc, bus.inst_is32); end
        checks++; if (bus.inst_data !== 32'hF000F800) begin errors++; $display("FAIL split_data: got %h want F000F800", bus.inst_data); end
        @(posedge clk); #2;
        checks++; if (req_log.size() < 2 || req_log[0] !== 16'h001C || req_log[1] !== 16'h0020) begin errors++; $display("FAIL split_addrs: got %0d requests want 001C,0020", req_log.size()); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        ack_delay      = 3;
        bus.inst_ready = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.rom_req && cyc < 50);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        checks++; if (bus.rom_req !== 1'b0 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got %b/%b want 0/0", bus.rom_req, bus.inst_valid); end
        repeat (2) @(posedge clk);
        #3;
        ack_delay = 1;
        clear_logs();
        rst = 1'b1;
        wait_insts(1);
        checks++; if (pc_log.size() < 1 || req_log.size() < 1 || req_log[0] !== 16'h0000 || pc_log[0] !== 16'h0000) begin
            errors++; $display("FAIL rstmid_restart: got %0d inst want first pc 0000 from addr 0000", pc_log.size());
        end
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        acks_seen         = 0;
        ack_delay         = 1;
        rst               = 1'b0;
        bus.inst_ready    = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_target = '0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h2000 + 16'(i);
        rom[8]  = 16'hF000;
        rom[9]  = 16'hF800;
        rom[15] = 16'hF000;
        rom[16] = 16'hF800;

        test_reset();
        test_sequential();
        test_bl_pair();
        test_branch_unaligned();
        test_branch_discard();
        test_fill_drain();
        test_split32();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
